my_segment: RTL and testbench

MY_SEGMENT -- requirements
Module: my_segment

---
 rtl/my_segment.sv | 96 +++++++++
 tb/tb_my_segment.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/my_segment.sv
// my_segment: registered 7-segment decoder with load strobe, blanking,
// decimal point and an error flag for codes that cannot be shown.
// Output registers hold the physical (polarity-adjusted) drive, so no
// logic sits between the flops and the pins.
module my_segment #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err
);

  // XOR mask turning logical (high-true) values into pin polarity
  localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_POL  = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       err_q, err_d;

  // Decode a code to {err, g..a}; hex letters only when enabled
  function automatic logic [7:0] decode_code(input logic [3:0] code,
                                             input logic       hex_en);
    logic [7:0] res;
    case (code)
      4'd0:    res = {1'b0, 7'h3F};
      4'd1:    res = {1'b0, 7'h06};
      4'd2:    res = {1'b0, 7'h5B};
      4'd3:    res = {1'b0, 7'h4F};
      4'd4:    res = {1'b0, 7'h66};
      4'd5:    res = {1'b0, 7'h6D};
      4'd6:    res = {1'b0, 7'h7D};
      4'd7:    res = {1'b0, 7'h07};
      4'd8:    res = {1'b0, 7'h7F};
      4'd9:    res = {1'b0, 7'h6F};
      4'd10:   res = hex_en ? {1'b0, 7'h77} : {1'b1, 7'h00};
      4'd11:   res = hex_en ? {1'b0, 7'h7C} : {1'b1, 7'h00};
      4'd12:   res = hex_en ? {1'b0, 7'h39} : {1'b1, 7'h00};
      4'd13:   res = hex_en ? {1'b0, 7'h5E} : {1'b1, 7'h00};
      4'd14:   res = hex_en ? {1'b0, 7'h79} : {1'b1, 7'h00};
      4'd15:   res = hex_en ? {1'b0, 7'h71} : {1'b1, 7'h00};
      default: res = {1'b1, 7'h00};
    endcase
    return res;
  endfunction

  logic [7:0] dec_s;

  // Next-state: hold unless loading; blank overrides digit and dp_in
  always_comb begin
    seg_d = seg_q;
    dp_d  = dp_q;
    err_d = err_q;
    dec_s = decode_code(digit, HEX_EN);
    if (en) begin
      if (blank) begin
        seg_d = SEG_POL;
        dp_d  = DP_POL;
        err_d = 1'b0;
      end else begin
        seg_d = dec_s[6:0] ^ SEG_POL;
        dp_d  = dp_in ^ DP_POL;
        err_d = dec_s[7];
      end
    end else begin
      seg_d = seg_q;
      dp_d  = dp_q;
      err_d = err_q;
    end
  end

  // Output registers; synchronous reset darkens the display and wins over en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_POL;
      dp_q  <= DP_POL;
      err_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      err_q <= err_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign err = err_q;

endmodule

// File: tb/tb_my_segment.sv
// Directed bench for my_segment: three instances share stimulus to cover
// active-low decimal, active-high decimal and active-high hex builds.
module tb_my_segment;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] digit;
  logic       blank;
  logic       dp_in;

  logic [6:0] seg_al, seg_hi, seg_hx;
  logic       dp_al, dp_hi, dp_hx;
  logic       err_al, err_hi, err_hx;

  int total_cnt = 0;
  int bad_cnt   = 0;

  my_segment #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_al (
    .clk(clk), .rst_n(rst_n), .en(en), .digit(digit), .blank(blank),
    .dp_in(dp_in), .seg(seg_al), .dp(dp_al), .err(err_al));

  my_segment #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .digit(digit), .blank(blank),
    .dp_in(dp_in), .seg(seg_hi), .dp(dp_hi), .err(err_hi));

  my_segment #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_hx (
    .clk(clk), .rst_n(rst_n), .en(en), .digit(digit), .blank(blank),
    .dp_in(dp_in), .seg(seg_hx), .dp(dp_hx), .err(err_hx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hand-computed logical patterns for digits 1..9,0
  logic [3:0] sweep_dig [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
  logic [6:0] sweep_exp [10] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};

  initial begin
    rst_n = 1'b0; en = 1'b1; digit = 4'd8; blank = 1'b0; dp_in = 1'b1;

    // reset for two cycles, with en active to show reset priority
    tick(); tick();
    chk_val("rst_seg_al", {1'b0, seg_al}, 8'h7F);
    chk_val("rst_dp_al",  {7'd0, dp_al},  8'h01);
    chk_val("rst_err_al", {7'd0, err_al}, 8'h00);
    chk_val("rst_seg_hi", {1'b0, seg_hi}, 8'h00);
    chk_val("rst_dp_hi",  {7'd0, dp_hi},  8'h00);

    // sweep 1..9,0 each held 10 cycles
    rst_n = 1'b1; dp_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      digit = sweep_dig[i];
      tick();
      chk_val("sweep_first", {1'b0, seg_hi}, {1'b0, sweep_exp[i]});
      chk_val("sweep_al",    {1'b0, seg_al}, {1'b0, ~sweep_exp[i]});
      for (int k = 0; k < 9; k++) tick();
      chk_val("sweep_held",  {1'b0, seg_hi}, {1'b0, sweep_exp[i]});
    end

    // hold: load 8 then en=0 with other inputs wiggling
    digit = 4'd8; en = 1'b1; tick();
    chk_val("hold_load", {1'b0, seg_hi}, 8'h7F);
    en = 1'b0; digit = 4'd3; blank = 1'b1; dp_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_val("hold_seg", {1'b0, seg_hi}, 8'h7F);
      chk_val("hold_dp",  {7'd0, dp_hi},  8'h00);
    end
    en = 1'b1; blank = 1'b0; dp_in = 1'b0; tick();
    chk_val("hold_reload", {1'b0, seg_hi}, 8'h4F);

    // invalid vs hex code 12
    digit = 4'd12; tick();
    chk_val("inv_seg_hi", {1'b0, seg_hi}, 8'h00);
    chk_val("inv_err_hi", {7'd0, err_hi}, 8'h01);
    chk_val("inv_seg_al", {1'b0, seg_al}, 8'h7F);
    chk_val("inv_err_al", {7'd0, err_al}, 8'h01);
    chk_val("hex_seg_c",  {1'b0, seg_hx}, 8'h39);
    chk_val("hex_err_c",  {7'd0, err_hx}, 8'h00);
    digit = 4'd15; tick();
    chk_val("hex_seg_f",  {1'b0, seg_hx}, 8'h71);
    chk_val("inv_err_f",  {7'd0, err_hi}, 8'h01);
    digit = 4'd10; tick();
    chk_val("hex_seg_a",  {1'b0, seg_hx}, 8'h77);

    // blank clears a pending error and overrides digit/dp_in
    digit = 4'd5; dp_in = 1'b1; blank = 1'b1; tick();
    chk_val("blank_seg", {1'b0, seg_hi}, 8'h00);
    chk_val("blank_dp",  {7'd0, dp_hi},  8'h00);
    chk_val("blank_err", {7'd0, err_hi}, 8'h00);
    chk_val("blank_al",  {1'b0, seg_al}, 8'h7F);
    chk_val("blank_dpal",{7'd0, dp_al},  8'h01);
    blank = 1'b0; tick();
    chk_val("unbl_seg",  {1'b0, seg_hi}, 8'h6D);
    chk_val("unbl_dp",   {7'd0, dp_hi},  8'h01);
    chk_val("unbl_al",   {1'b0, seg_al}, 8'h12);
    chk_val("unbl_dpal", {7'd0, dp_al},  8'h00);

    // back-to-back loads, one per edge
    dp_in = 1'b0;
    digit = 4'd2; tick(); chk_val("b2b_2", {1'b0, seg_hi}, 8'h5B);
    digit = 4'd3; tick(); chk_val("b2b_3", {1'b0, seg_hi}, 8'h4F);
    digit = 4'd4; tick(); chk_val("b2b_4", {1'b0, seg_hi}, 8'h66);

    // reset pulse between edges has no effect
    en = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk_val("glitch_rst", {1'b0, seg_hi}, 8'h66);

    // mid-sequence reset
    en = 1'b1; digit = 4'd7; tick();
    chk_val("mid_load7", {1'b0, seg_hi}, 8'h07);
    rst_n = 1'b0; digit = 4'd9; tick();
    chk_val("mid_rst_hi", {1'b0, seg_hi}, 8'h00);
    chk_val("mid_rst_al", {1'b0, seg_al}, 8'h7F);
    rst_n = 1'b1; tick();
    chk_val("mid_rel", {1'b0, seg_hi}, 8'h6F);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
